grant_requester: RTL and testbench

Requester-side client for the weighted round-robin arbiter. It buffers outbound data words in a small FIFO and raises `request` while words are pending. Each cycle the arbiter returns `grant` high, it pops one word onto the shared output port. One instance sits on each requester lane, so its `request` feeds one bit of the arbiter's `request` vector and its `grant` input is the matching bit of the arbiter's `grant` vector.

---
 rtl/grant_requester.sv | 116 +++++++++++
 tb/tb_grant_requester.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/grant_requester.sv
// grant_requester
//   Requester-side client for a weighted round-robin arbiter. Outbound words
//   are buffered in a small circular FIFO. `request` is raised while words are
//   pending, and one word is popped onto the shared output port on every cycle
//   in which `grant` is sampled high.
//
// Ports
//   clk, reset_n          : clock, synchronous active-low reset
//   in_valid/in_data      : upstream word offer
//   in_ready              : FIFO not full (decoded from registers only)
//   request               : request line to the arbiter (state decode only)
//   grant                 : this lane's grant bit
//   out_valid/out_data    : popped word, valid for one cycle after the grant
//   beat_count            : words sent, saturating
//   idle_grants           : grants received with an empty FIFO, saturating
module grant_requester #(
  parameter int DEPTH = 4,
  parameter int DW    = 8,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          request,
  input  logic          grant,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [CW-1:0] beat_count,
  output logic [7:0]    idle_grants
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = AW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, XFER = 2'd2} state_t;

  logic [DW-1:0]   mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CNTW-1:0] count, count_nxt;
  state_t          state, state_nxt;
  logic            push, pop;

  assign in_ready = (count != CNTW'(DEPTH));
  assign push     = in_valid && in_ready;
  // Pop only from words already stored; a same-cycle push into an empty FIFO
  // is not visible to this edge.
  assign pop      = grant && (count != '0);

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNTW'(1);
      2'b01:   count_nxt = count - CNTW'(1);
      default: count_nxt = count;
    endcase
  end

  // State transitions look at the post-update occupancy so that words left
  // behind when a slot ends keep `request` high with no gap.
  always_comb begin
    state_nxt = state;
    request   = 1'b0;
    case (state)
      IDLE: begin
        request = 1'b0;
        if (count_nxt != '0) state_nxt = REQ;
      end
      REQ: begin
        request = 1'b1;
        if (grant)                 state_nxt = XFER;
        else if (count_nxt == '0)  state_nxt = IDLE;
      end
      XFER: begin
        request = (count != '0);
        if (!grant) state_nxt = (count_nxt != '0) ? REQ : IDLE;
      end
      default: begin
        request   = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Storage array carries no reset; validity is tracked by count/pointers.
  always_ff @(posedge clk) begin
    if (reset_n && push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      beat_count  <= '0;
      idle_grants <= '0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      out_valid <= pop;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        out_data <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + AW'(1);
        if (beat_count != '1) beat_count <= beat_count + CW'(1);
      end
      if (grant && (count == '0) && (idle_grants != 8'hFF))
        idle_grants <= idle_grants + 8'd1;
    end
  end

endmodule

// File: tb/tb_grant_requester.sv
module tb_grant_requester;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       grant;

  logic        in_ready, request, out_valid;
  logic [7:0]  out_data, idle_grants;
  logic [15:0] beat_count;

  // Narrow-counter twin fed with the same stimulus, for beat saturation.
  logic        in_ready_s, request_s, out_valid_s;
  logic [7:0]  out_data_s, idle_grants_s;
  logic [3:0]  beat_count_s;

  grant_requester #(.DEPTH(DEPTH), .DW(8), .CW(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .request(request), .grant(grant),
    .out_valid(out_valid), .out_data(out_data),
    .beat_count(beat_count), .idle_grants(idle_grants));

  grant_requester #(.DEPTH(DEPTH), .DW(8), .CW(4)) dut_s (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_s), .request(request_s), .grant(grant),
    .out_valid(out_valid_s), .out_data(out_data_s),
    .beat_count(beat_count_s), .idle_grants(idle_grants_s));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: a queue of pending words plus plain counters.
  int         q[$];
  int         m_beat, m_idle;
  bit         m_ov, m_last_pop;
  logic [7:0] m_od;

  // Advance one clock: update the model from the inputs the DUT samples at
  // this edge, then move to 1 time unit after the edge.
  task automatic step();
    bit can_push, can_pop;
    if (!reset_n) begin
      q.delete();
      m_beat = 0; m_idle = 0; m_ov = 0; m_od = 8'h00; m_last_pop = 0;
    end else begin
      can_push = in_valid && (q.size() != DEPTH);
      can_pop  = grant && (q.size() != 0);
      if (can_pop) begin
        m_od = 8'(q.pop_front());
        m_beat++;
      end
      m_ov = can_pop;
      m_last_pop = can_pop;
      if (grant && !can_pop && m_idle < 255) m_idle++;
      if (can_push) q.push_back(int'(in_data));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_data = 8'h00; grant = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    step(); step();
    reset_n = 1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tests++; if (request !== 1'b0) begin fails++; $display("FAIL reset_request got %b want 0", request); end
    tests++; if (beat_count !== 16'd0 || idle_grants !== 8'd0) begin fails++;
      $display("FAIL reset_counters got %0d/%0d want 0/0", beat_count, idle_grants); end
    tests++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin fails++;
      $display("FAIL reset_out got %b/%h want 0/00", out_valid, out_data); end
  endtask

  task automatic test_single_word();
    in_valid = 1; in_data = 8'h5A;
    step();
    in_valid = 0;
    tests++; if (request !== 1'b1) begin fails++; $display("FAIL single_request got %b want 1", request); end
    grant = 1;
    step();
    grant = 0;
    tests++; if (out_valid !== 1'b1 || out_data !== 8'h5A) begin fails++;
      $display("FAIL single_data got %b/%h want 1/5a", out_valid, out_data); end
    tests++; if (beat_count !== 16'd1) begin fails++; $display("FAIL single_beat got %0d want 1", beat_count); end
    step();
    tests++; if (request !== 1'b0 || out_valid !== 1'b0) begin fails++;
      $display("FAIL single_after got req=%b ov=%b want 0/0", request, out_valid); end
  endtask

  task automatic test_full_slot();
    logic [7:0] exp;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1; in_data = 8'(i); step();
    end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_in_ready got %b want 0", in_ready); end
    in_data = 8'h05; step();
    in_valid = 0;
    tests++; if (in_ready !== 1'b0 || q.size() != 4) begin fails++;
      $display("FAIL full_refuse got in_ready=%b size=%0d want 0/4", in_ready, q.size()); end
    grant = 1;
    for (int i = 1; i <= 2; i++) begin
      step(); exp = 8'(i);
      tests++; if (out_valid !== 1'b1 || out_data !== exp) begin fails++;
        $display("FAIL slot1_word got %b/%h want 1/%h", out_valid, out_data, exp); end
    end
    grant = 0;
    step();
    tests++; if (request !== 1'b1) begin fails++; $display("FAIL slot_gap_request got %b want 1", request); end
    grant = 1;
    for (int i = 3; i <= 4; i++) begin
      step(); exp = 8'(i);
      tests++; if (out_valid !== 1'b1 || out_data !== exp) begin fails++;
        $display("FAIL slot2_word got %b/%h want 1/%h", out_valid, out_data, exp); end
    end
    step();
    grant = 0;
    tests++; if (out_valid !== 1'b0 || idle_grants !== 8'd1) begin fails++;
      $display("FAIL slot_idle got ov=%b idle=%0d want 0/1", out_valid, idle_grants); end
    step();
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1; in_data = 8'(i); step();
    end
    grant = 1; in_valid = 1; in_data = 8'h05;
    step();
    tests++; if (out_valid !== 1'b1 || out_data !== 8'h01) begin fails++;
      $display("FAIL fpp_pop got %b/%h want 1/01", out_valid, out_data); end
    tests++; if (in_ready !== 1'b1 || q.size() != 3) begin fails++;
      $display("FAIL fpp_count got in_ready=%b size=%0d want 1/3", in_ready, q.size()); end
    grant = 0;
    step();
    in_valid = 0;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL fpp_accept got in_ready=%b want 0", in_ready); end
    grant = 1;
    for (int i = 2; i <= 5; i++) begin
      step(); exp = 8'(i);
      tests++; if (out_valid !== 1'b1 || out_data !== exp) begin fails++;
        $display("FAIL fpp_drain got %b/%h want 1/%h", out_valid, out_data, exp); end
    end
    grant = 0;
    step();
  endtask

  task automatic test_streaming();
    int seen = 0;
    int beat0;
    logic [7:0] exp;
    beat0 = int'(beat_count);
    grant = 1;
    for (int c = 0; c < 24; c++) begin
      in_valid = (c < 16);
      in_data  = 8'(8'h10 + c);
      step();
      if (out_valid === 1'b1) begin
        exp = 8'(8'h10 + seen);
        tests++; if (seen >= 16 || out_data !== exp) begin fails++;
          $display("FAIL stream_word got %h idx=%0d want %h", out_data, seen, exp); end
        seen++;
      end
    end
    grant = 0; in_valid = 0;
    tests++; if (seen != 16) begin fails++; $display("FAIL stream_total got %0d want 16", seen); end
    tests++; if (int'(beat_count) != beat0 + 16) begin fails++;
      $display("FAIL stream_beat got %0d want %0d", beat_count, beat0 + 16); end
    step();
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = 8'(8'hA1 + i); step();
    end
    in_valid = 0; grant = 1;
    step();
    reset_n = 0;
    step();
    reset_n = 1; grant = 0;
    tests++; if (out_valid !== 1'b0 || out_data !== 8'h00 || request !== 1'b0 || in_ready !== 1'b1) begin fails++;
      $display("FAIL midrst_out got ov=%b od=%h req=%b rdy=%b want 0/00/0/1", out_valid, out_data, request, in_ready); end
    tests++; if (beat_count !== 16'd0 || idle_grants !== 8'd0) begin fails++;
      $display("FAIL midrst_counters got %0d/%0d want 0/0", beat_count, idle_grants); end
    in_valid = 1; in_data = 8'hAA; step();
    in_valid = 0; grant = 1; step();
    grant = 0;
    tests++; if (out_valid !== 1'b1 || out_data !== 8'hAA) begin fails++;
      $display("FAIL midrst_next got %b/%h want 1/aa", out_valid, out_data); end
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom_range(0, 99) < 55);
      in_data  = 8'($urandom);
      grant    = ($urandom_range(0, 99) < 45);
      step();
      tests++;
      if (out_valid !== m_ov || out_data !== m_od || beat_count !== 16'(m_beat) ||
          idle_grants !== 8'(m_idle) || in_ready !== (q.size() != DEPTH)) begin
        fails++;
        $display("FAIL random_state cyc=%0d got ov=%b od=%h beat=%0d idle=%0d rdy=%b want %b/%h/%0d/%0d/%b",
                 c, out_valid, out_data, beat_count, idle_grants, in_ready,
                 m_ov, m_od, m_beat, m_idle, (q.size() != DEPTH));
      end
      tests++;
      if ((q.size() != 0 && request !== 1'b1) || (q.size() == 0 && !m_last_pop && request !== 1'b0)) begin
        fails++;
        $display("FAIL random_request cyc=%0d got %b with %0d pending", c, request, q.size());
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_saturation();
    reset_n = 0; step(); reset_n = 1;
    grant = 1;
    for (int c = 0; c < 21; c++) begin
      in_valid = (c < 20); in_data = 8'(c); step();
    end
    in_valid = 0;
    tests++; if (beat_count !== 16'd20) begin fails++; $display("FAIL sat_beat_wide got %0d want 20", beat_count); end
    tests++; if (beat_count_s !== 4'hF) begin fails++; $display("FAIL sat_beat_narrow got %0d want 15", beat_count_s); end
    for (int c = 0; c < 300; c++) step();
    grant = 0;
    tests++; if (idle_grants !== 8'd255 || idle_grants !== 8'(m_idle)) begin fails++;
      $display("FAIL sat_idle got %0d want 255", idle_grants); end
    tests++; if (beat_count_s !== 4'hF) begin fails++; $display("FAIL sat_beat_hold got %0d want 15", beat_count_s); end
    step();
  endtask

  initial begin
    idle_inputs();
    reset_n = 0;
    test_reset();
    test_single_word();
    test_full_slot();
    test_full_push_pop();
    test_streaming();
    test_reset_mid_burst();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule
